// File: rtl/hdmi_audio_sample_packetizer_if.sv
// Bus bundle between the audio sample FIFO, the packetizer and the HDMI
// data-island scheduler.
//   FIFO side   : sampleFifoEmpty, sampleFifoReadData (valid one cycle after
//                 the pop), sampleFifoReadEnable
//   Config      : spdifCategoryCode, spdifSamplingFreq, spdifWordLength
//   Packet side : packetValid/packetReady handshake, packetHeader {HB2,HB1,HB0},
//                 packetBody (4 x 56-bit subpackets), frameCount
// Modport master is the packetizer; modport slave is its environment.
interface hdmi_audio_sample_packetizer_if;
  logic         sampleFifoEmpty;
  logic [31:0]  sampleFifoReadData;
  logic         sampleFifoReadEnable;
  logic [7:0]   spdifCategoryCode;
  logic [3:0]   spdifSamplingFreq;
  logic [3:0]   spdifWordLength;
  logic         packetValid;
  logic         packetReady;
  logic [23:0]  packetHeader;
  logic [223:0] packetBody;
  logic [7:0]   frameCount;

  modport master (
    input  sampleFifoEmpty, sampleFifoReadData,
    input  spdifCategoryCode, spdifSamplingFreq, spdifWordLength,
    input  packetReady,
    output sampleFifoReadEnable, packetValid, packetHeader, packetBody, frameCount
  );

  modport slave (
    output sampleFifoEmpty, sampleFifoReadData,
    output spdifCategoryCode, spdifSamplingFreq, spdifWordLength,
    output packetReady,
    input  sampleFifoReadEnable, packetValid, packetHeader, packetBody, frameCount
  );
endinterface

// File: rtl/hdmi_audio_sample_packetizer.sv
// HDMI layout-0 Audio Sample Packet builder.
// Pops 32-bit stereo samples ({left16, right16}) from the audio FIFO and packs
// 1..MAX_SLOTS of them into one packet, one IEC 60958 frame per sample.
// A packet is closed when it is full or the FIFO runs dry, then offered on
// packetValid until packetReady.
// Ports:
//   pixelClock  - sole clock
//   asyncResetN - async active-low reset
//   bus         - packetizer_if.master (FIFO pop, channel-status config,
//                 packet handshake/header/body, next frame index)
module hdmi_audio_sample_packetizer #(
  parameter int MAX_SLOTS    = 4,
  parameter int BLOCK_FRAMES = 192
) (
  input logic                           pixelClock,
  input logic                           asyncResetN,
  hdmi_audio_sample_packetizer_if.master bus
);
  localparam int         NUM_SP  = 4;
  localparam logic [2:0] LAST_CNT = 3'(MAX_SLOTS - 1);
  localparam logic [7:0] LAST_FRM = 8'(BLOCK_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, READ, CAPTURE, EMIT} state_e;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
    logic        b;   // block start
    logic        cl;  // channel-status bit, left
    logic        cr;  // channel-status bit, right
  } slot_t;

  state_e              state_q;
  logic [2:0]          count_q;
  logic [7:0]          frame_q;
  slot_t [NUM_SP-1:0]  slot_q;
  logic [NUM_SP-1:0]   present_q;
  logic                rd_en_q;
  logic                vld_q;
  logic [23:0]         hdr_d;
  logic [223:0]        body_d;

  // Channel-status bit for frame k. Channel number is sent LSB first, so
  // left (1) sets bit 20 and right (2) sets bit 21.
  function automatic logic cs_bit(input logic [7:0] k, input logic rch,
                                  input logic [7:0] cat, input logic [3:0] sf,
                                  input logic [3:0] wl);
    logic b;
    b = 1'b0;
    if (k >= 8'd8 && k <= 8'd15)       b = cat[k[2:0]];
    else if (k >= 8'd20 && k <= 8'd23) b = rch ? (k == 8'd21) : (k == 8'd20);
    else if (k >= 8'd24 && k <= 8'd27) b = sf[k[1:0]];
    else if (k >= 8'd32 && k <= 8'd35) b = wl[k[1:0]];
    return b;
  endfunction

  always_ff @(posedge pixelClock or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q   <= IDLE;
      count_q   <= '0;
      frame_q   <= '0;
      slot_q    <= '0;
      present_q <= '0;
      rd_en_q   <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!bus.sampleFifoEmpty) begin
            state_q <= READ;
            rd_en_q <= 1'b1;
          end
        end
        READ: state_q <= CAPTURE;
        CAPTURE: begin
          slot_q[count_q[1:0]] <= slot_t'{
            l:  bus.sampleFifoReadData[31:16],
            r:  bus.sampleFifoReadData[15:0],
            b:  (frame_q == 8'd0),
            cl: cs_bit(frame_q, 1'b0, bus.spdifCategoryCode,
                       bus.spdifSamplingFreq, bus.spdifWordLength),
            cr: cs_bit(frame_q, 1'b1, bus.spdifCategoryCode,
                       bus.spdifSamplingFreq, bus.spdifWordLength)};
          present_q[count_q[1:0]] <= 1'b1;
          count_q <= count_q + 3'd1;
          frame_q <= (frame_q == LAST_FRM) ? 8'd0 : frame_q + 8'd1;
          // Empty here already reflects this pop, so a dry FIFO closes the packet.
          if (count_q == LAST_CNT || bus.sampleFifoEmpty) begin
            state_q <= EMIT;
            vld_q   <= 1'b1;
          end else begin
            state_q <= READ;
            rd_en_q <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.packetReady) begin
            state_q   <= IDLE;
            vld_q     <= 1'b0;
            count_q   <= '0;
            slot_q    <= '0;
            present_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Header/body are built from the slot registers and gated by valid, so
  // they read as zero whenever no packet is offered (including in reset).
  always_comb begin
    hdr_d  = '0;
    body_d = '0;
    if (vld_q) begin
      hdr_d[7:0] = 8'h02;
      for (int i = 0; i < NUM_SP; i++) begin
        hdr_d[8+i]  = present_q[i];
        hdr_d[20+i] = slot_q[i].b;
        // V/U are zero, so parity covers only the sample bits and C.
        body_d[56*i +: 56] = {^slot_q[i].r ^ slot_q[i].cr, slot_q[i].cr, 2'b00,
                              ^slot_q[i].l ^ slot_q[i].cl, slot_q[i].cl, 2'b00,
                              slot_q[i].r, 8'h00, slot_q[i].l, 8'h00};
      end
    end
  end

  assign bus.sampleFifoReadEnable = rd_en_q;
  assign bus.packetValid          = vld_q;
  assign bus.packetHeader         = hdr_d;
  assign bus.packetBody           = body_d;
  assign bus.frameCount           = frame_q;
endmodule

// File: tb/tb_hdmi_audio_sample_packetizer.sv
// Randomized bench for hdmi_audio_sample_packetizer with a FIFO model and a
// packet-level reference model (samples chunked into packets of up to 4,
// IEC frame counter modulo 192, channel-status block built as bit vectors).
module tb_hdmi_audio_sample_packetizer;
  logic pixelClock = 1'b0;
  logic asyncResetN = 1'b0;
  always #5 pixelClock = ~pixelClock;

  hdmi_audio_sample_packetizer_if bus();

  hdmi_audio_sample_packetizer dut (
    .pixelClock (pixelClock),
    .asyncResetN(asyncResetN),
    .bus        (bus.master)
  );

  typedef struct {
    logic [23:0]  hdr;
    logic [223:0] body;
    logic [7:0]   fc;
  } pkt_t;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] fq[$];     // FIFO contents
  logic [31:0] pend[$];   // samples pushed but not yet chunked by the model
  pkt_t        exp_q[$];  // expected packets in order
  int          mframe = 0;
  logic [191:0] csl, csr;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // FIFO model: data valid the cycle after the pop.
  always @(posedge pixelClock) begin
    if (bus.sampleFifoReadEnable) begin
      chk("pop_not_empty", 256'(fq.size() != 0), 256'(1));
      if (fq.size() != 0) bus.sampleFifoReadData <= fq.pop_front();
      bus.sampleFifoEmpty <= (fq.size() == 0);
    end
  end

  // Packet monitor: a packet offered with ready high is taken on the next edge.
  always @(negedge pixelClock) begin
    if (asyncResetN && bus.packetValid && bus.packetReady) begin
      chk("exp_available", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) begin
        pkt_t p;
        p = exp_q.pop_front();
        chk("header", 256'(bus.packetHeader), 256'(p.hdr));
        chk("body", 256'(bus.packetBody), 256'(p.body));
        chk("frame_count", 256'(bus.frameCount), 256'(p.fc));
      end
    end
  end

  task automatic set_cfg(input logic [7:0] cat, input logic [3:0] sf, input logic [3:0] wl);
    bus.spdifCategoryCode = cat;
    bus.spdifSamplingFreq = sf;
    bus.spdifWordLength   = wl;
    csl = '0;
    csl[15:8]  = cat;
    csl[27:24] = sf;
    csl[35:32] = wl;
    csr = csl;
    csl[20] = 1'b1;  // channel 1
    csr[21] = 1'b1;  // channel 2
  endtask

  task automatic push(input logic [31:0] s);
    fq.push_back(s);
    pend.push_back(s);
    bus.sampleFifoEmpty = 1'b0;
  endtask

  // Chunk pending samples into expected packets.
  task automatic model_flush();
    pkt_t p;
    int n;
    logic [31:0] s;
    logic [23:0] lw, rw;
    while (pend.size() > 0) begin
      n = (pend.size() > 4) ? 4 : pend.size();
      p.hdr = 24'h000002;
      p.body = '0;
      for (int i = 0; i < n; i++) begin
        s = pend.pop_front();
        lw = {s[31:16], 8'h00};
        rw = {s[15:0], 8'h00};
        p.hdr[8+i]  = 1'b1;
        p.hdr[20+i] = (mframe == 0);
        p.body[56*i +: 24]    = lw;
        p.body[56*i+24 +: 24] = rw;
        p.body[56*i+50] = csl[mframe];
        p.body[56*i+51] = ($countones(lw) + csl[mframe]) % 2 == 1;
        p.body[56*i+54] = csr[mframe];
        p.body[56*i+55] = ($countones(rw) + csr[mframe]) % 2 == 1;
        mframe = (mframe + 1) % 192;
      end
      p.fc = 8'(mframe);
      exp_q.push_back(p);
    end
  endtask

  task automatic do_reset();
    asyncResetN = 1'b0;
    exp_q.delete();
    pend.delete();
    mframe = 0;
    repeat (2) @(posedge pixelClock);
    #1 asyncResetN = 1'b1;
  endtask

  // Run until every expected packet is taken; ready high pct% of cycles.
  task automatic drain(input int pct);
    int cyc;
    cyc = 0;
    while (1) begin
      @(posedge pixelClock);
      #1;
      if (exp_q.size() == 0 && fq.size() == 0) break;
      if (cyc > 3000) begin
        chk("drain_timeout", 256'(0), 256'(1));
        exp_q.delete();
        break;
      end
      bus.packetReady = ($urandom_range(99) < pct);
      cyc++;
    end
    bus.packetReady = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pixelClock);
      if (bus.packetValid) begin ok = 1'b1; break; end
    end
    chk("valid_seen", 256'(ok), 256'(1));
  endtask

  initial begin
    bit ok;
    int rd_at, vld_at, rd_cnt;
    bus.sampleFifoEmpty    = 1'b1;
    bus.sampleFifoReadData = '0;
    bus.packetReady        = 1'b0;
    set_cfg(8'h00, 4'h0, 4'h0);

    // Reset held: FIFO inputs toggle, nothing moves.
    for (int i = 0; i < 8; i++) begin
      @(posedge pixelClock);
      #1;
      bus.sampleFifoEmpty    = $urandom_range(1);
      bus.sampleFifoReadData = $urandom;
      bus.packetReady        = $urandom_range(1);
      @(negedge pixelClock);
      chk("rst_rd_en", 256'(bus.sampleFifoReadEnable), 256'(0));
      chk("rst_valid", 256'(bus.packetValid), 256'(0));
      chk("rst_hdr_body", {bus.packetHeader, bus.packetBody, bus.frameCount}, 256'(0));
    end
    @(posedge pixelClock);
    #1;
    bus.sampleFifoEmpty = 1'b1;
    bus.packetReady     = 1'b0;
    asyncResetN         = 1'b1;
    repeat (3) @(negedge pixelClock);
    chk("post_rst_fc", 256'(bus.frameCount), 256'(0));
    chk("post_rst_idle_rd", 256'(bus.sampleFifoReadEnable), 256'(0));

    // Single sample: latency, fixed expected header/body.
    @(posedge pixelClock);
    #1;
    bus.packetReady = 1'b1;
    push(32'h1234ABCD);
    model_flush();
    rd_at = -1; vld_at = -1; rd_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge pixelClock);
      if (bus.sampleFifoReadEnable) begin rd_cnt++; if (rd_at < 0) rd_at = i; end
      if (bus.packetValid && vld_at < 0) begin
        vld_at = i;
        chk("t2_hdr", 256'(bus.packetHeader), 256'(24'h100102));
        chk("t2_sp0", 256'(bus.packetBody[55:0]), 256'(56'h08_ABCD00_123400));
        chk("t2_sp123", 256'(bus.packetBody[223:56]), 256'(0));
        chk("t2_fc", 256'(bus.frameCount), 256'(1));
      end
    end
    chk("t2_rd_at", 256'(rd_at), 256'(1));
    chk("t2_rd_pulses", 256'(rd_cnt), 256'(1));
    chk("t2_vld_at", 256'(vld_at), 256'(3));
    drain(100);

    // Six preloaded samples after a fresh reset: packets of 4 then 2.
    do_reset();
    set_cfg(8'($urandom), 4'($urandom), 4'($urandom));
    @(posedge pixelClock);
    #1;
    for (int i = 0; i < 6; i++) push($urandom);
    model_flush();
    chk("t3_hdr1_model", 256'(exp_q[0].hdr[15:0]), 256'(16'h0F02));
    drain(100);
    @(negedge pixelClock);
    chk("t3_fc", 256'(bus.frameCount), 256'(6));

    // Stall: packet held while the FIFO fills, no reads.
    @(posedge pixelClock);
    #1;
    push($urandom);
    model_flush();
    wait_valid(ok);
    for (int i = 0; i < 20; i++) begin
      @(posedge pixelClock);
      #1;
      push($urandom);
      @(negedge pixelClock);
      chk("stall_valid", 256'(bus.packetValid), 256'(1));
      chk("stall_rd_en", 256'(bus.sampleFifoReadEnable), 256'(0));
      if (exp_q.size() != 0)
        chk("stall_hold", {bus.packetHeader, bus.packetBody}, {exp_q[0].hdr, exp_q[0].body});
    end
    model_flush();
    @(posedge pixelClock);
    #1;
    bus.packetReady = 1'b1;
    @(posedge pixelClock);
    #1;
    chk("stall_accept_1cyc", 256'(exp_q.size()), 256'(5));
    drain(100);

    // 193 single-sample packets across a block boundary.
    do_reset();
    set_cfg(8'h01, 4'h2, 4'h0);
    for (int i = 0; i < 193; i++) begin
      @(posedge pixelClock);
      #1;
      push($urandom);
      model_flush();
      drain(100);
      if (i == 191) begin
        @(negedge pixelClock);
        chk("fc_wrap", 256'(bus.frameCount), 256'(0));
      end
    end

    // Random bursts with random backpressure and config.
    for (int b = 0; b < 30; b++) begin
      set_cfg(8'($urandom), 4'($urandom), 4'($urandom));
      @(posedge pixelClock);
      #1;
      for (int i = 0; i < int'($urandom_range(10, 1)); i++) push($urandom);
      model_flush();
      drain(60);
    end

    // Reset while a packet is offered.
    @(posedge pixelClock);
    #1;
    push($urandom);
    model_flush();
    wait_valid(ok);
    #2 asyncResetN = 1'b0;
    exp_q.delete();
    mframe = 0;
    #1;
    chk("rst_emit_valid", 256'(bus.packetValid), 256'(0));
    chk("rst_emit_hdr", 256'(bus.packetHeader), 256'(0));
    repeat (2) @(posedge pixelClock);
    #1 asyncResetN = 1'b1;
    @(posedge pixelClock);
    #1;
    push($urandom);
    model_flush();
    chk("rst_emit_b_model", 256'(exp_q[0].hdr[23:16]), 256'(8'h10));
    drain(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
